// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The divider sits on the slave modport; decode/writeback drive the master side.
interface div_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, busy
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Opcode values mirror ALU_op_t: DIV=16, DIVU=17, REM=18, REMU=19; other opcodes are dropped.
module div_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam logic [4:0] OpDiv  = 5'd16;
  localparam logic [4:0] OpDivu = 5'd17;
  localparam logic [4:0] OpRem  = 5'd18;
  localparam logic [4:0] OpRemu = 5'd19;

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            isrem_q, isrem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic            accept;
  logic            is_div_op;
  logic            signed_op;
  logic            rem_op;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    is_div_op = 1'b0;
    signed_op = 1'b0;
    rem_op    = 1'b0;
    unique case (bus.in_op)
      OpDiv:  begin is_div_op = 1'b1; signed_op = 1'b1; end
      OpDivu: begin is_div_op = 1'b1; end
      OpRem:  begin is_div_op = 1'b1; signed_op = 1'b1; rem_op = 1'b1; end
      OpRemu: begin is_div_op = 1'b1; rem_op = 1'b1; end
      default: ;
    endcase
  end

  assign a_mag = (signed_op && bus.in_a[XLEN-1]) ? ('0 - bus.in_a) : bus.in_a;
  assign b_mag = (signed_op && bus.in_b[XLEN-1]) ? ('0 - bus.in_b) : bus.in_b;

  // rem_q < div_q always holds, so the borrow bit alone tells whether shifted >= div.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, div_q};

  assign quo_fix = negq_q ? ('0 - quo_q) : quo_q;
  assign rem_fix = negr_q ? ('0 - rem_q) : rem_q;

  assign bus.in_ready   = (state_q == StIdle) && !bus.flush;
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    isrem_d  = isrem_q;
    result_d = result_q;
    rd_d     = rd_q;

    unique case (state_q)
      StIdle: begin
        if (accept && is_div_op) begin
          rd_d    = bus.in_rd;
          isrem_d = rem_op;
          if (bus.in_b == '0) begin
            result_d = rem_op ? bus.in_a : '1;
            state_d  = StDone;
          end else if (signed_op && (bus.in_a == IntMin) && (bus.in_b == '1)) begin
            result_d = rem_op ? '0 : IntMin;
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            div_d   = b_mag;
            negq_d  = signed_op && (bus.in_a[XLEN-1] ^ bus.in_b[XLEN-1]);
            negr_d  = signed_op && bus.in_a[XLEN-1];
            cnt_d   = CntW'(XLEN - 1);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        result_d = isrem_q ? rem_fix : quo_fix;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Kill overrides everything, including a retire in the same cycle.
    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      isrem_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      isrem_q  <= isrem_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and model-checked bench for div_unit: expected results queue at issue, compare at retire.
module tb_div_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpDiv  = 5'd16;
  localparam logic [4:0] OpDivu = 5'd17;
  localparam logic [4:0] OpRem  = 5'd18;
  localparam logic [4:0] OpRemu = 5'd19;
  localparam logic [31:0] IntMin = 32'h8000_0000;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_unit_if #(.XLEN(XLEN), .RD_W(RD_W)) dif ();

  div_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OpDivu: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OpRemu: r = (b == 0) ? a : a % b;
      OpDiv: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == IntMin && b == 32'hFFFF_FFFF) r = IntMin;
        else r = $signed(a) / $signed(b);
      end
      OpRem: begin
        if (b == 0) r = a;
        else if (a == IntMin && b == 32'hFFFF_FFFF) r = '0;
        else r = $signed(a) % $signed(b);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 0) return 1;
    if ((op == OpDiv || op == OpRem) && a == IntMin && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Waits for in_ready, presents one request, returns #1 after the accept edge.
  task automatic start(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int n;
    n = 0;
    while (!dif.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("in_ready_timeout", 64'(dif.in_ready), 64'd1);
    dif.in_valid = 1'b1;
    dif.in_op    = op;
    dif.in_a     = a;
    dif.in_b     = b;
    dif.in_rd    = rd;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    // Inputs must be ignored after the accept edge.
    dif.in_op    = OpDivu;
    dif.in_a     = $urandom;
    dif.in_b     = $urandom;
    dif.in_rd    = 5'($urandom);
  endtask

  task automatic collect(input int hold);
    int n;
    exp_t e;
    logic [31:0] held;
    n = 1;
    while (!dif.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    e = sb.pop_front();
    check("out_valid", 64'(dif.out_valid), 64'd1);
    check("latency", 64'(n), 64'(e.lat));
    check("result", 64'(dif.out_result), 64'(e.res));
    check("out_rd", 64'(dif.out_rd), 64'(e.rd));
    check("busy_done", 64'(dif.busy), 64'd1);
    check("in_ready_done", 64'(dif.in_ready), 64'd0);
    held = dif.out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(dif.out_valid), 64'd1);
      check("hold_result", 64'(dif.out_result), 64'(held));
      check("hold_in_ready", 64'(dif.in_ready), 64'd0);
    end
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    check("retire_valid", 64'(dif.out_valid), 64'd0);
    check("retire_in_ready", 64'(dif.in_ready), 64'd1);
    check("retire_busy", 64'(dif.busy), 64'd0);
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int hold);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.lat = exp_lat(op, a, b);
    sb.push_back(e);
    start(op, a, b, rd);
    collect(hold);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    dif.flush     = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_op     = OpAdd;
    dif.in_a      = '0;
    dif.in_b      = '0;
    dif.in_rd     = '0;
    dif.out_ready = 1'b0;

    #12;
    check("rst_out_valid", 64'(dif.out_valid), 64'd0);
    check("rst_out_result", 64'(dif.out_result), 64'd0);
    check("rst_out_rd", 64'(dif.out_rd), 64'd0);
    check("rst_busy", 64'(dif.busy), 64'd0);
    check("rst_in_ready", 64'(dif.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(OpDivu, 32'd100, 32'd7, 5'd5, 32'd14, 0);
    do_op(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 0);
    do_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 0);
    do_op(OpRemu, 32'hFFFF_FFFF, 32'd16, 5'd3, 32'd15, 0);
    do_op(OpDiv, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 0);
    do_op(OpRemu, 32'd5, 32'd0, 5'd6, 32'd5, 0);
    do_op(OpRem, 32'hFFFF_FFFB, 32'd0, 5'd7, 32'hFFFF_FFFB, 0);
    do_op(OpDiv, IntMin, 32'hFFFF_FFFF, 5'd8, IntMin, 0);
    do_op(OpRem, IntMin, 32'hFFFF_FFFF, 5'd9, 32'd0, 0);
    do_op(OpDivu, 32'd9, 32'd3, 5'd10, 32'd3, 10);
    do_op(OpDiv, 32'd100, 32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2, 0);
    do_op(OpRem, 32'd100, 32'hFFFF_FFF9, 5'd12, 32'd2, 0);

    for (int i = 0; i < 12; i++) begin
      op = OpDiv + 5'(i % 4);
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 5 == 1) b = b >> 20;
      do_op(op, a, b, 5'(i + 13), model(op, a, b), 0);
    end

    // Non-divide opcode is taken and dropped.
    start(OpAdd, 32'd1, 32'd2, 5'd3);
    check("nondiv_busy", 64'(dif.busy), 64'd0);
    expect_silence("nondiv_no_valid", 40);

    // Flush ten cycles into the iteration.
    start(OpDivu, 32'd1000, 32'd3, 5'd7);
    repeat (9) @(posedge clk);
    #1;
    check("calc_busy", 64'(dif.busy), 64'd1);
    dif.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", 64'(dif.busy), 64'd0);
    check("flush_valid", 64'(dif.out_valid), 64'd0);
    check("flush_in_ready_low", 64'(dif.in_ready), 64'd0);
    dif.flush = 1'b0;
    #1;
    check("flush_in_ready", 64'(dif.in_ready), 64'd1);
    expect_silence("flush_no_valid", 40);

    // Flush wins over a same-cycle request.
    dif.flush    = 1'b1;
    dif.in_valid = 1'b1;
    dif.in_op    = OpDivu;
    dif.in_a     = 32'd50;
    dif.in_b     = 32'd5;
    #1;
    check("flush_blocks_ready", 64'(dif.in_ready), 64'd0);
    @(posedge clk); #1;
    dif.flush    = 1'b0;
    dif.in_valid = 1'b0;
    check("flush_blocks_accept", 64'(dif.busy), 64'd0);

    // Reset in the middle of an iteration.
    start(OpDiv, 32'hFFFF_FF9C, 32'd7, 5'd3);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(dif.busy), 64'd0);
    check("midrst_valid", 64'(dif.out_valid), 64'd0);
    check("midrst_result", 64'(dif.out_result), 64'd0);
    check("midrst_rd", 64'(dif.out_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(dif.in_ready), 64'd1);
    expect_silence("midrst_no_valid", 40);

    // Unit still works after the disruptions.
    do_op(OpDivu, 32'd100, 32'd7, 5'd5, 32'd14, 0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
